sr_decomp: RTL and testbench

SR_DECOMP -- requirements
Module: sr_decomp

---
 rtl/sr_decomp.sv | 104 ++++++++++
 tb/tb_sr_decomp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_decomp.sv
// Block decompressor: one 64-bit compressed word in, two 64-bit beats of four sign-extended 16-bit lanes out.
// Optional protocol checking (missing marker, truncated block) is built when SR_DECOMP_ERR_CHECK_EN is defined.
module sr_decomp (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] data_i,
  input  logic        valid_i,
  input  logic        sop_i,
  output logic        ready_o,
  output logic [63:0] data_o,
  output logic        valid_o,
  output logic        sop_o,
  output logic        eop_o,
  input  logic        ready_i,
  output logic        err_o
);

  typedef enum logic [1:0] {EMPTY, HI, LO} state_t;

  state_t      state;
  logic [63:0] buffer;
  logic [2:0]  wcnt;   // index the next accepted word will take
  logic        first;  // buffered word is word 0 of its block
  logic        xfer_in;
  logic [2:0]  idx;
  logic [31:0] half;
  logic [63:0] dec;

  assign ready_o = (state == EMPTY) || (state == LO && ready_i);
  assign valid_o = (state != EMPTY);
  assign xfer_in = valid_i && ready_o;
  assign idx     = sop_i ? 3'd0 : wcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      buffer <= '0;
      wcnt   <= '0;
      first  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            buffer <= data_i;
            wcnt   <= idx + 3'd1;
            first  <= (idx == 3'd0);
            state  <= HI;
          end
        end
        HI: begin
          if (ready_i) state <= LO;
        end
        LO: begin
          if (ready_i) begin
            if (xfer_in) begin
              buffer <= data_i;
              wcnt   <= idx + 3'd1;
              first  <= (idx == 3'd0);
              state  <= HI;
            end else begin
              state <= EMPTY;
            end
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_comb begin
    half = (state == HI) ? buffer[63:32] : buffer[31:0];
    dec  = '0;
    for (int k = 0; k < 4; k++) begin
      dec[16*k +: 16] = {{8{half[8*k+7]}}, half[8*k +: 8]};
    end
    // bit 63 of word 0 is the block marker, so lane 3 of that beat carries only 7 data bits
    if (state == HI && first) begin
      dec[63:48] = {{9{buffer[62]}}, buffer[62:56]};
    end
  end

  assign data_o = valid_o ? dec : '0;
  assign sop_o  = (state == HI) && first;
  // wcnt wraps to 0 exactly when the buffered word was word 7
  assign eop_o  = (state == LO) && (wcnt == 3'd0);

`ifdef SR_DECOMP_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= xfer_in && (((idx == 3'd0) && !data_i[63]) ||
                           (sop_i && (wcnt != 3'd0)));
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sr_decomp.sv
// Scoreboard bench for sr_decomp: directed block scenarios, then randomized traffic and backpressure
// checked against an arithmetic model of the block/lane rules.
module tb_sr_decomp;

`ifdef SR_DECOMP_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_i;
  logic        valid_i;
  logic        sop_i;
  logic        ready_o;
  logic [63:0] data_o;
  logic        valid_o;
  logic        sop_o;
  logic        eop_o;
  logic        ready_i;
  logic        err_o;

  sr_decomp dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .sop_i(sop_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .sop_o(sop_o),
    .eop_o(eop_o), .ready_i(ready_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        s;
    logic        e;
  } beat_t;

  beat_t q[$];
  int    nxt = 0;
  bit    err_exp = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  bit    rnd_ready = 1'b0;
  bit    ready_man = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Each lane is its byte read as a signed number; the marker lane of word 0 is a signed 7-bit number.
  function automatic logic [63:0] decode(input logic [31:0] h, input bit marker);
    logic [63:0]        r;
    logic signed [7:0]  b;
    logic signed [6:0]  m;
    logic signed [15:0] v;
    for (int k = 0; k < 4; k++) begin
      b = h[8*k +: 8];
      v = b;
      r[16*k +: 16] = v;
    end
    if (marker) begin
      m = h[30:24];
      v = m;
      r[63:48] = v;
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_man;
    end
  end

  // Monitor: the model holds at most one word (two beats); compare, then retire, then accept.
  always @(negedge clk) begin
    bit   exp_valid;
    bit   exp_ready;
    int   idx;
    if (rst) begin
      q.delete();
      nxt = 0;
      err_exp = 1'b0;
    end else begin
      chk("err", err_o, err_exp);
      exp_valid = (q.size() != 0);
      exp_ready = !exp_valid ? 1'b1 : ((q.size() == 2) ? 1'b0 : ready_i);
      chk("valid", valid_o, exp_valid);
      chk("ready", ready_o, exp_ready);
      if (exp_valid) begin
        chk("data", data_o, q[0].d);
        chk("sop", sop_o, q[0].s);
        chk("eop", eop_o, q[0].e);
        if (ready_i) void'(q.pop_front());
      end else begin
        chk("idle_data", data_o, 64'd0);
        chk("idle_flags", {sop_o, eop_o}, 2'b00);
      end
      err_exp = 1'b0;
      if (valid_i && exp_ready) begin
        idx = sop_i ? 0 : nxt;
        err_exp = ERR_EN && (((idx == 0) && !data_i[63]) || (sop_i && (nxt != 0)));
        nxt = (idx + 1) % 8;
        q.push_back('{d: decode(data_i[63:32], idx == 0), s: (idx == 0), e: 1'b0});
        q.push_back('{d: decode(data_i[31:0], 1'b0), s: 1'b0, e: (idx == 7)});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [63:0] d, input bit s);
    int t = 0;
    valid_i = 1'b1;
    data_i  = d;
    sop_i   = s;
    do begin
      @(negedge clk);
      t++;
    end while (!ready_o && t < 200);
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_o=0 for %0d cycles expected acceptance", t);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    sop_i   = 1'b0;
  endtask

  function automatic logic [63:0] rnd_word();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int c0;
    int t;
    rst = 1'b1; valid_i = 1'b0; sop_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_data", data_o, 64'd0);
    chk("rst_err", err_o, 1'b0);
    @(posedge clk); #1;

    // Single word with known decode
    send(64'h8000_0000_7F01_FF80, 1'b1);
    @(negedge clk);
    chk("w0_beat0", data_o, 64'h0000_0000_0000_0000);
    chk("w0_sop", sop_o, 1'b1);
    @(negedge clk);
    chk("w0_beat1", data_o, 64'h007F_0001_FFFF_FF80);
    @(posedge clk); #1;

    send(64'hC000_0000_0000_0000, 1'b1);
    @(negedge clk);
    chk("marker_lane", data_o, 64'hFFC0_0000_0000_0000);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // Full block back to back: one word per two cycles
    c0 = cyc;
    for (int i = 0; i < 8; i++) send({1'b1, rnd_word() >> 1}, i == 0);
    chk("throughput", cyc - c0, 15);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure for 5 cycles while word 3 sits in its HI beat
    for (int i = 0; i < 4; i++) send({1'b1, rnd_word() >> 1}, i == 0);
    ready_man = 1'b0;
    repeat (5) @(posedge clk);
    #1 ready_man = 1'b1;
    for (int i = 4; i < 8; i++) send(rnd_word(), 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Truncated block, then a word 0 without its marker
    for (int i = 0; i < 4; i++) send({1'b1, rnd_word() >> 1}, i == 0);
    send(64'hFFFF_0000_1234_5678, 1'b1);
    @(negedge clk);
    chk("trunc_sop", sop_o, 1'b1);
    @(posedge clk); #1;
    for (int i = 1; i < 8; i++) send(rnd_word(), 1'b0);
    send(64'h0000_0000_0000_0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Reset during the LO beat of word 2
    for (int i = 0; i < 3; i++) send({1'b1, rnd_word() >> 1}, i == 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_valid", valid_o, 1'b0);
    chk("rstmid_ready", ready_o, 1'b1);
    @(posedge clk); #1;
    send(64'hA5A5_5A5A_0102_8384, 1'b0);
    @(negedge clk);
    chk("rstmid_sop", sop_o, 1'b1);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure and input gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] w;
      w = rnd_word();
      if ($urandom_range(0, 7) != 0) w[63] = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(w, $urandom_range(0, 9) == 0);
    end
    rnd_ready = 1'b0;
    ready_man = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
